// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the bridge-side SPI master and spi_slave_regfile.
// Carries spi_miso_oe as well when SPI_SLAVE_MISO_OE_EN is defined.
interface spi_slave_regfile_if;
  logic spi_clk;
  logic spi_mosi;
  logic spi_cs_n;
  logic spi_miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic spi_miso_oe;

  modport master (output spi_clk, spi_mosi, spi_cs_n, input spi_miso, spi_miso_oe);
  modport slave  (input spi_clk, spi_mosi, spi_cs_n, output spi_miso, spi_miso_oe);
`else
  modport master (output spi_clk, spi_mosi, spi_cs_n, input spi_miso);
  modport slave  (input spi_clk, spi_mosi, spi_cs_n, output spi_miso);
`endif
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target terminating 41-bit {rw, addr[7:0], data[31:0]} frames into a 32-bit register file.
// Optional MISO output-enable (spi_miso_oe) is built when SPI_SLAVE_MISO_OE_EN is defined.
module spi_slave_regfile #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_regfile_if.slave    spi,
  output logic                  wr_valid,
  output logic [7:0]            wr_addr,
  output logic [31:0]           wr_data,
  output logic                  frame_done,
  output logic                  frame_err,
  input  logic [7:0]            dbg_addr,
  output logic [31:0]           dbg_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_CS} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [31:0] rx_shift;
  logic [31:0] tx_shift;
  logic [5:0]  bit_cnt;
  logic        rw;
  logic [7:0]  addr;
  logic        miso_r;
  logic [31:0] regs [DEPTH];

  logic        start, shift_rx, latch_hdr, shift_tx, finish, abort;
  logic        hdr_rw;
  logic [7:0]  hdr_addr;
  logic [31:0] rx_word;

  function automatic logic mapped(input logic [7:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // CS chain resets high so reset release never looks like a chip-select edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  assign hdr_rw   = rx_shift[7];
  assign hdr_addr = {rx_shift[6:0], mosi_s};
  assign rx_word  = {rx_shift[30:0], mosi_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // CS edges are tested before SCLK edges so a coincident CS rise wins
  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_rx   = 1'b0;
    latch_hdr  = 1'b0;
    shift_tx   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = HDR;
          start      = 1'b1;
        end
      end
      HDR: begin
        if (cs_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (sclk_rise) begin
          shift_rx = 1'b1;
          if (bit_cnt == 6'd8) begin
            latch_hdr  = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (sclk_rise) begin
          shift_rx = 1'b1;
          if (bit_cnt == 6'd40) begin
            finish     = 1'b1;
            state_next = WAIT_CS;
          end
        end else if (sclk_fall) begin
          shift_tx = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift   <= '0;
      tx_shift   <= '0;
      bit_cnt    <= '0;
      rw         <= 1'b0;
      addr       <= '0;
      miso_r     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_valid   <= 1'b0;
      frame_done <= finish;
      frame_err  <= abort;

      if (start) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (shift_rx) begin
        rx_shift <= rx_word;
        bit_cnt  <= bit_cnt + 6'd1;
      end

      if (latch_hdr) begin
        rw       <= hdr_rw;
        addr     <= hdr_addr;
        tx_shift <= (!hdr_rw && mapped(hdr_addr)) ? regs[hdr_addr[AW-1:0]] : '0;
      end else if (shift_tx && !rw) begin
        tx_shift <= {tx_shift[30:0], 1'b0};
      end

      if (state_next != DATA)  miso_r <= 1'b0;
      else if (shift_tx && !rw) miso_r <= tx_shift[31];

      if (finish && rw && mapped(addr)) begin
        regs[addr[AW-1:0]] <= rx_word;
        wr_valid           <= 1'b1;
        wr_addr            <= addr;
        wr_data            <= rx_word;
      end
    end
  end

  assign spi.spi_miso = miso_r;

`ifdef SPI_SLAVE_MISO_OE_EN
  logic oe_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) oe_r <= 1'b0;
    else      oe_r <= (state_next != IDLE);
  end

  assign spi.spi_miso_oe = oe_r;
`endif

  always_comb begin
    dbg_rdata = '0;
    if (mapped(dbg_addr)) dbg_rdata = regs[dbg_addr[AW-1:0]];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: the SPI master task issues frames, monitors compare
// strobes and captured MISO words against expectations queued at issue time.
module tb_spi_slave_regfile;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 8;

  typedef struct packed {
    logic        wv;
    logic        fd;
    logic        fe;
    logic [7:0]  a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, frame_done, frame_err;
  logic [7:0]  wr_addr, dbg_addr;
  logic [31:0] wr_data, dbg_rdata;

  int checks   = 0;
  int failures = 0;

  ev_t         ev_exp[$];
  logic [40:0] miso_exp[$];
  logic [40:0] miso_obs[$];

  always #5 clk = ~clk;

  spi_slave_regfile_if sif ();

  spi_slave_regfile #(.DEPTH(16), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (sif),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dbg_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(name, 64'(dbg_rdata), 64'(exp));
  endtask

  // Mode-0 master: MOSI changes while SCLK is low, MISO sampled just before each rising edge
  task automatic spi_frame(input logic rw, input logic [7:0] a, input logic [31:0] d,
                           input int unsigned nbits, input int unsigned extra,
                           input int unsigned gap);
    logic [40:0] f;
    logic [40:0] cap;
    f   = {rw, a, d};
    cap = '0;
    sif.spi_cs_n = 1'b0;
    wait_clks(HALF);
    for (int unsigned i = 0; i < nbits; i++) begin
      sif.spi_mosi = f[40-i];
      wait_clks(HALF);
      cap = {cap[39:0], sif.spi_miso};
      sif.spi_clk = 1'b1;
      wait_clks(HALF);
      sif.spi_clk = 1'b0;
    end
    for (int unsigned i = 0; i < extra; i++) begin
      wait_clks(HALF);
      check("miso_extra_pulse", 64'(sif.spi_miso), 64'(0));
      sif.spi_clk = 1'b1;
      wait_clks(HALF);
      sif.spi_clk = 1'b0;
    end
    wait_clks(HALF);
    sif.spi_cs_n = 1'b1;
    if (nbits == 41) miso_obs.push_back(cap);
    wait_clks(gap);
  endtask

  task automatic expect_ev(input logic wv, input logic fd, input logic fe,
                           input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e = '{wv: wv, fd: fd, fe: fe, a: a, d: d};
    ev_exp.push_back(e);
  endtask

  // Strobe monitor
  initial begin : ev_monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && (wr_valid || frame_done || frame_err)) begin
        if (ev_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got wv/fd/fe=%b%b%b expected none",
                   wr_valid, frame_done, frame_err);
        end else begin
          e = ev_exp.pop_front();
          check("strobe_flags", 64'({wr_valid, frame_done, frame_err}), 64'({e.wv, e.fd, e.fe}));
          if (e.wv) begin
            check("wr_addr", 64'(wr_addr), 64'(e.a));
            check("wr_data", 64'(wr_data), 64'(e.d));
          end
        end
      end
    end
  end

  // MISO word monitor
  initial begin : miso_monitor
    logic [40:0] obs;
    forever begin
      @(negedge clk);
      if (miso_obs.size() != 0) begin
        obs = miso_obs.pop_front();
        if (miso_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_miso_frame: got %0h expected none", obs);
        end else begin
          check("miso_frame", 64'(obs), 64'(miso_exp.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned drain;
    rst          = 1'b0;
    dbg_addr     = '0;
    sif.spi_clk  = 1'b0;
    sif.spi_mosi = 1'b0;
    sif.spi_cs_n = 1'b1;

    // Reset with inputs toggling randomly
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      sif.spi_clk  = 1'($urandom);
      sif.spi_mosi = 1'($urandom);
      sif.spi_cs_n = 1'($urandom);
    end
    #1;
    check("rst_miso", 64'(sif.spi_miso), 64'(0));
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    for (int unsigned i = 0; i < 16; i++) dbg_check("rst_dbg", 8'(i), 32'h0);
    @(negedge clk);
    sif.spi_clk  = 1'b0;
    sif.spi_mosi = 1'b0;
    sif.spi_cs_n = 1'b1;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(4);

    // Mapped write
    expect_ev(1'b1, 1'b1, 1'b0, 8'h03, 32'hA5A5_1234);
    miso_exp.push_back(41'h0);
    spi_frame(1'b1, 8'h03, 32'hA5A5_1234, 41, 0, 4);
    dbg_check("dbg_after_write3", 8'h03, 32'hA5A5_1234);

    // Read-back
    expect_ev(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    miso_exp.push_back({9'h0, 32'hA5A5_1234});
    spi_frame(1'b0, 8'h03, 32'h0, 41, 0, 4);

    // Unmapped write then read
    expect_ev(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    miso_exp.push_back(41'h0);
    spi_frame(1'b1, 8'h20, 32'hFFFF_FFFF, 41, 0, 4);
    dbg_check("dbg_unmapped", 8'h20, 32'h0);
    dbg_check("dbg_3_unchanged", 8'h03, 32'hA5A5_1234);
    expect_ev(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    miso_exp.push_back(41'h0);
    spi_frame(1'b0, 8'h20, 32'h0, 41, 0, 4);

    // Abort after 20 bits, then a full write to the same register
    expect_ev(1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    spi_frame(1'b1, 8'h05, 32'hDEAD_BEEF, 20, 0, 4);
    dbg_check("dbg_5_after_abort", 8'h05, 32'h0);
    expect_ev(1'b1, 1'b1, 1'b0, 8'h05, 32'hCAFE_F00D);
    miso_exp.push_back(41'h0);
    spi_frame(1'b1, 8'h05, 32'hCAFE_F00D, 41, 0, 4);
    dbg_check("dbg_5_after_write", 8'h05, 32'hCAFE_F00D);

    // Read with 4 extra SCLK pulses after bit 41
    expect_ev(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    miso_exp.push_back({9'h0, 32'hCAFE_F00D});
    spi_frame(1'b0, 8'h05, 32'h0, 41, 4, 4);

    // Back-to-back frames on the last mapped register, one clk of CS high between them
    expect_ev(1'b1, 1'b1, 1'b0, 8'h0F, 32'h0F0F_0F0F);
    miso_exp.push_back(41'h0);
    spi_frame(1'b1, 8'h0F, 32'h0F0F_0F0F, 41, 0, 1);
    expect_ev(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    miso_exp.push_back({9'h0, 32'h0F0F_0F0F});
    spi_frame(1'b0, 8'h0F, 32'h0, 41, 0, 4);
    dbg_check("dbg_15", 8'h0F, 32'h0F0F_0F0F);

`ifdef SPI_SLAVE_MISO_OE_EN
    // Output enable follows synced CS with SYNC+1 clk latency on both edges
    expect_ev(1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    sif.spi_cs_n = 1'b0;
    wait_clks(SYNC);
    check("oe_before_rise", 64'(sif.spi_miso_oe), 64'(0));
    wait_clks(1);
    check("oe_after_rise", 64'(sif.spi_miso_oe), 64'(1));
    wait_clks(HALF);
    sif.spi_cs_n = 1'b1;
    wait_clks(SYNC);
    check("oe_before_fall", 64'(sif.spi_miso_oe), 64'(1));
    wait_clks(1);
    check("oe_after_fall", 64'(sif.spi_miso_oe), 64'(0));
    wait_clks(4);
`endif

    drain = 0;
    while ((ev_exp.size() != 0 || miso_exp.size() != 0) && drain < 200) begin
      wait_clks(1);
      drain++;
    end
    wait_clks(4);
    check("ev_queue_drained", 64'(ev_exp.size()), 64'(0));
    check("miso_queue_drained", 64'(miso_exp.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
